// File: rtl/audio_pkg.sv
// Shared audio stream definitions for the I2S receive path and the FIFO bus bridge.
// Contents: sample/sequence/word widths, the packed output word and the receiver
// FSM state type.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned SEQ_W    = 3;
  localparam int unsigned DATA_W   = 1 + SEQ_W + SAMPLE_W;
  localparam int unsigned OVF_W    = 16;

  // One tagged sample as carried on source_data.
  typedef struct packed {
    logic                ch;
    logic [SEQ_W-1:0]    seq;
    logic [SAMPLE_W-1:0] sample;
  } audio_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_SHIFT,
    ST_WAIT
  } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings the three asynchronous I2S pins into the clk domain.
// Ports: clk/reset (sync, active-high); bclk, lrclk, sdata pins in;
//        bclk_rise one-clk pulse on a synced bclk 0->1, with lrclk_sync/sdata_sync
//        registered alongside so they are valid in the same cycle as the pulse.
module i2s_sync_edge
  import audio_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdata,
  output logic bclk_rise,
  output logic lrclk_sync,
  output logic sdata_sync
);

  // {bclk, lrclk, sdata}
  logic [2:0] meta;
  logic [2:0] sync;
  logic       bclk_prev;

  // Two-flop synchroniser, then edge detect on the synced bclk.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta       <= '0;
      sync       <= '0;
      bclk_prev  <= 1'b0;
      bclk_rise  <= 1'b0;
      lrclk_sync <= 1'b0;
      sdata_sync <= 1'b0;
    end else begin
      meta       <= {bclk, lrclk, sdata};
      sync       <= meta;
      bclk_prev  <= sync[2];
      bclk_rise  <= sync[2] & ~bclk_prev;
      lrclk_sync <= sync[1];
      sdata_sync <= sync[0];
    end
  end

endmodule

// File: rtl/i2s_rx_packer.sv
// I2S ADC receiver: deserialises each channel slot, tags it with channel and frame
// sequence, and offers it on a valid/ready stream through a 2-entry buffer.
// Ports: clk/reset (sync, active-high); enable capture level; i2s_bclk/i2s_lrclk/
//        i2s_sdata async codec pins; source_valid/source_data/source_ready stream;
//        overflow sticky drop flag; overflow_count saturating drop counter.
module i2s_rx_packer
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int unsigned SEQ_W    = audio_pkg::SEQ_W,
  parameter int unsigned DATA_W   = audio_pkg::DATA_W,
  parameter int unsigned OVF_W    = audio_pkg::OVF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sdata,
  output logic              source_valid,
  output logic [DATA_W-1:0] source_data,
  input  logic              source_ready,
  output logic              overflow,
  output logic [OVF_W-1:0]  overflow_count
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_W);

  if (DATA_W != 1 + SEQ_W + SAMPLE_W || DATA_W != $bits(audio_word_t)) begin : g_width_check
    $error("i2s_rx_packer: DATA_W must equal 1+SEQ_W+SAMPLE_W");
  end

  logic bclk_rise;
  logic lrclk_s;
  logic sdata_s;

  i2s_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .bclk       (i2s_bclk),
    .lrclk      (i2s_lrclk),
    .sdata      (i2s_sdata),
    .bclk_rise  (bclk_rise),
    .lrclk_sync (lrclk_s),
    .sdata_sync (sdata_s)
  );

  rx_state_t           state;
  logic                lr_prev;
  logic                ch;
  logic [SAMPLE_W-2:0] shreg;   // MSB-first bits so far; the last bit joins on push
  logic [CNT_W-1:0]    bitcnt;
  logic [SEQ_W-1:0]    seq;

  logic        lr_edge_c;
  logic        push_c;
  audio_word_t push_word_c;

  assign lr_edge_c = bclk_rise && (lrclk_s != lr_prev);
  assign push_c    = enable && bclk_rise && !lr_edge_c && (state == ST_SHIFT) &&
                     (bitcnt == CNT_W'(SAMPLE_W - 1));

  always_comb begin
    push_word_c        = '0;
    push_word_c.ch     = ch;
    push_word_c.seq    = seq;
    push_word_c.sample = {shreg, sdata_s};
  end

  // Slot framing FSM; an lr_edge always restarts framing on the new channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      lr_prev <= 1'b0;
      ch      <= 1'b0;
      shreg   <= '0;
      bitcnt  <= '0;
      seq     <= '0;
    end else begin
      if (bclk_rise) lr_prev <= lrclk_s;
      if (!enable) begin
        state <= ST_IDLE;
      end else if (bclk_rise) begin
        case (state)
          ST_IDLE, ST_WAIT: begin
            if (lr_edge_c) begin
              state <= ST_SKIP;
              ch    <= lrclk_s;
            end
          end
          ST_SKIP: begin
            state  <= ST_SHIFT;
            bitcnt <= '0;
          end
          ST_SHIFT: begin
            if (lr_edge_c) begin
              // Short slot: the partial sample is abandoned silently.
              state <= ST_SKIP;
              ch    <= lrclk_s;
            end else begin
              shreg <= {shreg[SAMPLE_W-3:0], sdata_s};
              if (bitcnt == CNT_W'(SAMPLE_W - 1)) begin
                state <= ST_WAIT;
                if (ch) seq <= seq + SEQ_W'(1);
              end else begin
                bitcnt <= bitcnt + CNT_W'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  audio_word_t mem_q [0:1];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count_q;

  logic        pop_c;
  logic        accept_c;
  logic        drop_c;
  logic        rd_next_c;
  logic [1:0]  count_next_c;
  audio_word_t head_next_c;

  assign pop_c        = source_valid && source_ready;
  assign accept_c     = push_c && ((count_q != 2'd2) || pop_c);
  assign drop_c       = push_c && (count_q == 2'd2) && !pop_c;
  assign rd_next_c    = pop_c ? ~rd_ptr : rd_ptr;
  assign count_next_c = count_q + 2'(accept_c) - 2'(pop_c);
  // A word written this cycle into the next head slot bypasses the array.
  assign head_next_c  = (accept_c && (wr_ptr == rd_next_c)) ? push_word_c : mem_q[rd_next_c];

  // Output buffer with registered head; a pop frees the slot for a same-cycle push.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0]       <= '0;
      mem_q[1]       <= '0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      count_q        <= 2'd0;
      source_valid   <= 1'b0;
      source_data    <= '0;
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else begin
      if (accept_c) begin
        mem_q[wr_ptr] <= push_word_c;
        wr_ptr        <= ~wr_ptr;
      end
      rd_ptr       <= rd_next_c;
      count_q      <= count_next_c;
      source_valid <= (count_next_c != 2'd0);
      if (count_next_c != 2'd0) source_data <= DATA_W'(head_next_c);
      if (drop_c) begin
        overflow <= 1'b1;
        if (overflow_count != {OVF_W{1'b1}}) overflow_count <= overflow_count + OVF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_packer.sv
// Directed-random bench for i2s_rx_packer: drives I2S slots at clk/16, predicts the
// tagged words from the slot contents, and checks stream order, drops and counters.
module tb_i2s_rx_packer;
  import audio_pkg::*;

  localparam int unsigned SW = 24;
  localparam int unsigned QW = 3;
  localparam int unsigned DW = 28;
  localparam int unsigned OW = 16;

  logic          clk = 1'b0;
  logic          reset, enable, bclk, lrclk, sdata, ready;
  logic          valid, valid_s, ovf, ovf_s;
  logic [DW-1:0] data, data_s;
  logic [OW-1:0] ocnt;
  logic [1:0]    ocnt_s;

  always #10 clk = ~clk;

  i2s_rx_packer #(.SAMPLE_W(SW), .SEQ_W(QW), .DATA_W(DW), .OVF_W(OW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .source_valid(valid), .source_data(data), .source_ready(ready),
    .overflow(ovf), .overflow_count(ocnt)
  );

  // Narrow-counter copy on the same pins to reach counter saturation quickly.
  i2s_rx_packer #(.SAMPLE_W(SW), .SEQ_W(QW), .DATA_W(DW), .OVF_W(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .source_valid(valid_s), .source_data(data_s), .source_ready(ready),
    .overflow(ovf_s), .overflow_count(ocnt_s)
  );

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  logic [QW-1:0] exp_seq;
  logic [SW-1:0] smp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Accepted words are collected here; data must hold while stalled.
  logic          p_valid = 1'b0;
  logic          p_ready = 1'b0;
  logic [DW-1:0] p_data  = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (p_valid && !p_ready && valid) chk("stall_hold", 32'(data), 32'(p_data));
      if (valid && ready) got_q.push_back(data);
    end
    p_valid <= valid;
    p_ready <= ready;
    p_data  <= data;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // One bclk period; lrclk/sdata change with the falling edge, 8 clk per half.
  task automatic send_bit(input logic lr, input logic d, input bit pulse);
    bclk = 1'b0; lrclk = lr; sdata = d;
    repeat (8) @(posedge clk);
    #3 bclk = 1'b1;
    if (pulse) begin
      // ready high exactly for the clk in which this last bit is pushed
      repeat (3) @(posedge clk);
      #1 ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
      repeat (4) @(posedge clk);
      #2;
    end else begin
      repeat (8) @(posedge clk);
      #3;
    end
    bclk = 1'b0;
  endtask

  // Slot: lrclk edge bit, one delay bit, SW data bits MSB first, random filler.
  task automatic send_slot(input logic ch, input logic [SW-1:0] s, input int len,
                           input bit pulse_last);
    for (int j = 0; j < len; j++) begin
      logic d;
      d = 1'($urandom_range(0, 1));
      if (j >= 2 && j < 2 + int'(SW)) d = s[int'(SW) - 1 - (j - 2)];
      send_bit(ch, d, pulse_last && (j == int'(SW) + 1));
    end
  endtask

  task automatic exp_word(input logic ch, input logic [SW-1:0] s);
    exp_q.push_back({ch, exp_seq, s});
    if (ch) exp_seq = exp_seq + QW'(1);
  endtask

  task automatic full_slot(input logic ch, input bit expect_it);
    logic [SW-1:0] s;
    s = SW'($urandom);
    send_slot(ch, s, 32, 1'b0);
    if (expect_it) exp_word(ch, s);
  endtask

  task automatic check_stream(input string tag);
    for (int k = 0; k < 64 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; bclk = 1'b0; lrclk = 1'b1; sdata = 1'b0; ready = 1'b1;
    exp_seq = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ocnt", 32'(ocnt), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #3;

    // Known samples, then one more frame: seq 0 shared by L/R, then 1.
    send_slot(1'b1, SW'($urandom), 4, 1'b0);
    send_slot(1'b0, 24'hABCDEF, 32, 1'b0); exp_word(1'b0, 24'hABCDEF);
    send_slot(1'b1, 24'h123456, 32, 1'b0); exp_word(1'b1, 24'h123456);
    chk("first_left_const", 32'(exp_q[0]), 32'h0ABCDEF);
    full_slot(1'b0, 1'b1);
    full_slot(1'b1, 1'b1);
    check_stream("basic");

    // Buffer full, ready pulsed in the push cycle: no drop.
    ready = 1'b0;
    full_slot(1'b0, 1'b1);
    full_slot(1'b1, 1'b1);
    smp = SW'($urandom);
    send_slot(1'b0, smp, 32, 1'b1); exp_word(1'b0, smp);
    chk("poppush_ovf", 32'(ovf), 32'd0);
    chk("poppush_ocnt", 32'(ocnt), 32'd0);
    chk("popush_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    check_stream("pop_push");
    full_slot(1'b1, 1'b1);
    check_stream("pop_push_tail");

    // Stall for three samples: two kept, the third dropped.
    ready = 1'b0;
    full_slot(1'b0, 1'b1);
    full_slot(1'b1, 1'b1);
    full_slot(1'b0, 1'b0);
    chk("drop_ovf", 32'(ovf), 32'd1);
    chk("drop_ocnt", 32'(ocnt), 32'd1);
    chk("drop_ocnt_sat", 32'(ocnt_s), 32'd1);
    chk("drop_valid", 32'(valid), 32'd1);
    chk("drop_head", 32'(data), 32'(exp_q[0]));
    chk("drop_no_pop", 32'(got_q.size()), 32'd0);
    ready = 1'b1;
    check_stream("drop_drain");
    full_slot(1'b1, 1'b1);

    // Left slot cut after 10 data bits: no word, right word intact.
    send_slot(1'b0, SW'($urandom), 12, 1'b0);
    full_slot(1'b1, 1'b1);
    check_stream("short_slot");

    // Eight frames: seq runs through the 7->0 wrap.
    for (int f = 0; f < 8; f++) begin
      full_slot(1'b0, 1'b1);
      full_slot(1'b1, 1'b1);
    end
    check_stream("seq_wrap");

    // Four more drops: wide counter 5, 2-bit counter pinned at all-ones.
    ready = 1'b0;
    full_slot(1'b0, 1'b1);
    full_slot(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) full_slot(1'(k), 1'b0);
    chk("sat_ocnt", 32'(ocnt), 32'd5);
    chk("sat_ocnt_narrow", 32'(ocnt_s), 32'd3);
    chk("sat_ovf_narrow", 32'(ovf_s), 32'd1);
    ready = 1'b1;
    check_stream("sat_drain");

    // Reset in the middle of a left slot with a full buffer.
    ready = 1'b0;
    full_slot(1'b0, 1'b0);
    full_slot(1'b1, 1'b0);
    send_slot(1'b0, SW'($urandom), 14, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_ocnt", 32'(ocnt), 32'd0);
    chk("midrst_ocnt_narrow", 32'(ocnt_s), 32'd0);
    reset = 1'b0;
    exp_seq = '0;
    ready = 1'b1;
    #2;
    full_slot(1'b1, 1'b1);
    full_slot(1'b0, 1'b1);
    full_slot(1'b1, 1'b1);
    check_stream("after_reset");

    // Disable mid-slot: nothing more is pushed, buffered word still drains.
    ready = 1'b0;
    full_slot(1'b0, 1'b1);
    send_slot(1'b1, SW'($urandom), 14, 1'b0);
    enable = 1'b0;
    send_slot(1'b1, SW'($urandom), 18, 1'b0);
    full_slot(1'b0, 1'b0);
    full_slot(1'b1, 1'b0);
    chk("dis_no_pop", 32'(got_q.size()), 32'd0);
    ready = 1'b1;
    check_stream("enable_off");
    chk("dis_empty", 32'(valid), 32'd0);
    enable = 1'b1;
    full_slot(1'b0, 1'b1);
    check_stream("re_enable");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
